traffic_light: RTL and testbench
================================

# traffic_light

Highway/farm-road traffic-light controller. A single car sensor on the farm road drives a Moore state machine with cycle-count timers. The highway stays green until the farm road requests service. The block sits between the intersection sensor input and the six lamp drivers (three per road).

## Interface
Parameters:
- `HG_MIN_CYCLES`, default 250_000_000: minimum highway-green duration in clock cycles (2.5 s at 100 MHz); must be ≥ 1.
- `YELLOW_CYCLES`, default 50_000_000: exact duration of each yellow phase in cycles; must be ≥ 1.
- `FG_MAX_CYCLES`, default 250_000_000: maximum farm-green duration in cycles; must be ≥ 1.

Ports:
- `clk`, input, 1: single clock (100 MHz nominal); all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-high (asserted = 1 despite the name).
- `car`, input, 1: farm-road car sensor; 1 = vehicle waiting. Synchronous to `clk`.
- `light`, output, 6: lamp drive, one-hot per road.
  - `[5:3]` = highway `{red, yellow, green}`.
  - `[2:0]` = farm road `{red, yellow, green}`.

## Operation
- States and `light` value (Moore; decoded from the state register only):
  - INIT: `000000`, all lamps off.
  - HG (highway green / farm red): `001100`.
  - HY (highway yellow / farm red): `010100`.
  - FG (highway red / farm green): `100001`.
  - FY (highway red / farm yellow): `100010`.
- One internal cycle counter, 32 bits, counts cycles spent in the current state. It clears to 0 on every state change and saturates at max.
- Transitions, evaluated each rising edge:
  - INIT → HG unconditionally.
  - HG → HY when counter ≥ `HG_MIN_CYCLES`−1 and `car`=1. Otherwise stay in HG, indefinitely while `car`=0.
  - HY → FG when counter = `YELLOW_CYCLES`−1.
  - FG → FY when `car`=0 or counter = `FG_MAX_CYCLES`−1, whichever comes first.
  - FY → HG when counter = `YELLOW_CYCLES`−1.
- `car` is sampled only in HG (after minimum green) and in FG. It is ignored in HY, FY and INIT.
- A request arriving during the HG minimum is held by level: if `car` is still 1 when the minimum expires, HG exits. No latching of `car` pulses.
- Unreachable state encodings go to INIT on the next edge.
- Safety invariant: never both roads non-red simultaneously. Exactly one lamp per road is lit in all states except INIT.

## Timing
- Reset: with `rst_n`=1 at a rising edge → state INIT, counter 0, `light`=`000000` after that edge. Reset mid-phase (any state) aborts immediately to INIT.
- First edge with `rst_n`=0 → HG, so `light`=`001100` one cycle after reset release.
- HG lasts ≥ `HG_MIN_CYCLES` cycles.
- HY and FY last exactly `YELLOW_CYCLES` cycles.
- FG lasts 1 to `FG_MAX_CYCLES` cycles.
- `light` changes only on the clock edge that changes state. Zero-cycle combinational path from state to `light`; no path from `car` to `light`.
- `car` rising in HG after the minimum has expired → HY visible after the next edge (1-cycle latency).
- `car`=0 sampled in FG → FY after the next edge.
- Simultaneous `car`=0 and FG timeout both yield FY (same result).

## Test plan
Bench parameters: `HG_MIN_CYCLES`=10, `YELLOW_CYCLES`=3, `FG_MAX_CYCLES`=8.

1. Reset held 2 cycles, release, `car`=0 held 1000 cycles → `light`=`000000` during reset, then `001100` from the first post-reset edge, constant throughout.
2. `car`=1 from cycle 2 after release → HG persists exactly 10 cycles, then `010100` for exactly 3 cycles, then `100001`.
3. In FG, drop `car` to 0 after 4 cycles → FG ends on the next edge, `100010` for 3 cycles, back to `001100`.
4. Keep `car`=1 continuously → FG lasts exactly 8 cycles, then FY for 3, HG for 10, HY for 3, repeating.
5. Assert `rst_n`=1 for one cycle while in HY and again in FG → `light`=`000000` next cycle, then `001100` the cycle after release.
6. Random `car` for 10^5 cycles → assertion never fires for both roads non-red at once, and exactly one lamp per road is lit except in INIT.

Source files
------------

// File: rtl/traffic_light.sv
// Highway/farm-road traffic-light controller: Moore FSM driven by a farm-road
// car sensor, with one saturating per-state cycle counter for the min/max/yellow timers.
module traffic_light #(
  parameter int unsigned HG_MIN_CYCLES = 250_000_000,
  parameter int unsigned YELLOW_CYCLES = 50_000_000,
  parameter int unsigned FG_MAX_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,  // active-high synchronous reset despite the name
  input  logic       car,
  output logic [5:0] light
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_HG   = 3'd1,
    S_HY   = 3'd2,
    S_FG   = 3'd3,
    S_FY   = 3'd4
  } state_t;

  localparam logic [31:0] HG_LAST = 32'(HG_MIN_CYCLES - 1);
  localparam logic [31:0] Y_LAST  = 32'(YELLOW_CYCLES - 1);
  localparam logic [31:0] FG_LAST = 32'(FG_MAX_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [5:0]  r_light;
  state_t      w_next;

  function automatic state_t f_next(input state_t s, input logic [31:0] cnt, input logic c);
    case (s)
      S_INIT:  f_next = S_HG;
      S_HG:    f_next = (cnt >= HG_LAST && c) ? S_HY : S_HG;
      S_HY:    f_next = (cnt == Y_LAST) ? S_FG : S_HY;
      S_FG:    f_next = (!c || cnt == FG_LAST) ? S_FY : S_FG;
      S_FY:    f_next = (cnt == Y_LAST) ? S_HG : S_FY;
      default: f_next = S_INIT;
    endcase
  endfunction

  // {hw red, hw yellow, hw green, farm red, farm yellow, farm green}
  function automatic logic [5:0] f_lamps(input state_t s);
    case (s)
      S_HG:    f_lamps = 6'b001_100;
      S_HY:    f_lamps = 6'b010_100;
      S_FG:    f_lamps = 6'b100_001;
      S_FY:    f_lamps = 6'b100_010;
      default: f_lamps = 6'b000_000;
    endcase
  endfunction

  assign w_next = f_next(r_state, r_cnt, car);

  // Lamps are registered from the next state, so they always match r_state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_light <= '0;
    end else begin
      r_state <= w_next;
      r_light <= f_lamps(w_next);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != 32'hFFFF_FFFF)
        r_cnt <= r_cnt + 32'd1;
    end
  end

  assign light = r_light;

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light with short timers (min green 10, yellow 3,
// farm max 8), followed by a random-sensor safety sweep.
module tb_traffic_light;

  localparam logic [5:0] L_OFF = 6'b000_000;
  localparam logic [5:0] L_HG  = 6'b001_100;
  localparam logic [5:0] L_HY  = 6'b010_100;
  localparam logic [5:0] L_FG  = 6'b100_001;
  localparam logic [5:0] L_FY  = 6'b100_010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       car;
  logic [5:0] light;

  int tests = 0;
  int fails = 0;

  traffic_light #(
    .HG_MIN_CYCLES(10),
    .YELLOW_CYCLES(3),
    .FG_MAX_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .car  (car),
    .light(light)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic expect_n(input string tag, input logic [5:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests++;
      assert (light === exp) else begin
        fails++;
        $error("FAIL %s[%0d]: light=%b expected %b", tag, i, light, exp);
      end
    end
  endtask

  task automatic check_safe(input int idx);
    logic hw_go, farm_go, ok;
    hw_go   = light[4] | light[3];
    farm_go = light[1] | light[0];
    ok = !(hw_go && farm_go) && $onehot(light[5:3]) && $onehot(light[2:0]);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL safety[%0d]: light=%b expected one lamp per road, not both non-red", idx, light);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    car   = 1'b0;

    // 1: reset for 2 cycles, then highway green held with no car
    expect_n("t1_rst", L_OFF, 2);
    rst_n = 1'b0;
    expect_n("t1_hg", L_HG, 1000);

    // 2: fresh start, car asserted early; HG 10, HY 3, then FG
    rst_n = 1'b1;
    expect_n("t2_rst", L_OFF, 1);
    rst_n = 1'b0;
    expect_n("t2_hg0", L_HG, 1);
    car = 1'b1;
    expect_n("t2_hg", L_HG, 9);
    expect_n("t2_hy", L_HY, 3);
    expect_n("t2_fg0", L_FG, 1);

    // 3: car leaves after 4 FG cycles -> FY 3, back to HG
    expect_n("t3_fg", L_FG, 3);
    car = 1'b0;
    expect_n("t3_fy", L_FY, 3);
    expect_n("t3_hg0", L_HG, 1);

    // 4: car held -> full cycle with FG timing out at 8
    car = 1'b1;
    expect_n("t4_hg", L_HG, 9);
    expect_n("t4_hy", L_HY, 3);
    expect_n("t4_fg", L_FG, 8);
    expect_n("t4_fy", L_FY, 3);
    expect_n("t4_hg2", L_HG, 10);
    expect_n("t4_hy2", L_HY, 3);
    expect_n("t4_fg2", L_FG, 1);

    // 5: reset pulse in FG, then again in HY
    rst_n = 1'b1;
    expect_n("t5_rst_fg", L_OFF, 1);
    rst_n = 1'b0;
    expect_n("t5_hg", L_HG, 10);
    expect_n("t5_hy", L_HY, 1);
    rst_n = 1'b1;
    expect_n("t5_rst_hy", L_OFF, 1);
    rst_n = 1'b0;
    expect_n("t5_hg2", L_HG, 1);

    // 6: random sensor, safety invariant every cycle
    for (int i = 0; i < 100000; i++) begin
      car = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_safe(i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
